fp_mult_result_buffer: RTL and testbench

//  Output stage directly downstream of fp_mult_top. Captures each product z and its
//  8-bit status, and queues the pairs in a first-word-fall-through FIFO.

---
 rtl/fp_mult_result_buffer_if.sv | 22 ++
 rtl/fp_mult_result_buffer.sv | 76 +++++++
 tb/tb_fp_mult_result_buffer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fp_mult_result_buffer_if.sv
// Handshake bundle between fp_mult_top, the result buffer and its consumer.
// The slave modport is the buffer's view; master is the surrounding producer/consumer.
interface fp_mult_result_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_z;
  logic [7:0]  in_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [7:0]  out_status;

  modport slave (
    input  in_valid, in_z, in_status, out_ready,
    output in_ready, out_valid, out_z, out_status
  );

  modport master (
    output in_valid, in_z, in_status, out_ready,
    input  in_ready, out_valid, out_z, out_status
  );
endinterface

// File: rtl/fp_mult_result_buffer.sv
// First-word-fall-through queue for multiplier products and status, with a sticky
// status OR, a saturating exception counter and a saturating drop counter.
module fp_mult_result_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  fp_mult_result_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 sticky_status,
  input  logic                       sticky_clr,
  output logic [CNT_W-1:0]           exc_count,
  output logic [CNT_W-1:0]           drop_count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_z  [DEPTH];
  logic [7:0]    mem_st [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, drop, exc_hit;

  // Flow control looks only at occupancy so neither side sees a combinational loop.
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push    = bus.in_valid & bus.in_ready;
  assign pop     = bus.out_valid & bus.out_ready;
  assign drop    = bus.in_valid & ~bus.in_ready;
  assign exc_hit = bus.in_status[1] | bus.in_status[2];

  assign bus.out_z      = bus.out_valid ? mem_z[rd_ptr]  : 32'h0;
  assign bus.out_status = bus.out_valid ? mem_st[rd_ptr] : 8'h0;

  // Storage needs no reset; reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_z[wr_ptr]  <= bus.in_z;
      mem_st[wr_ptr] <= bus.in_status;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // A clear still folds in this cycle's push/drop so no event is lost across it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_status <= '0;
      exc_count     <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
    end else if (sticky_clr) begin
      sticky_status <= push ? bus.in_status : 8'h0;
      exc_count     <= CNT_W'(push & exc_hit);
      drop_count    <= CNT_W'(drop);
      overflow      <= drop;
    end else begin
      if (push) sticky_status <= sticky_status | bus.in_status;
      if (push && exc_hit && exc_count != '1) exc_count <= exc_count + 1'b1;
      if (drop && drop_count != '1)           drop_count <= drop_count + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_mult_result_buffer.sv
// Directed bench for fp_mult_result_buffer: latency, ordering, full/drop, wrap, sticky and reset.
module tb_fp_mult_result_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        sticky_clr;
  logic [3:0]  count;
  logic [7:0]  sticky_status;
  logic [15:0] exc_count, drop_count;
  logic        overflow;
  int          total = 0;
  int          bad   = 0;

  fp_mult_result_buffer_if bus ();

  fp_mult_result_buffer #(.DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .count(count),
    .sticky_status(sticky_status), .sticky_clr(sticky_clr),
    .exc_count(exc_count), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and checks happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sticky_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_z = '0; bus.in_status = '0; bus.out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_count", count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_z", bus.out_z, 0);
    chk("rst_sticky", sticky_status, 0);
    chk("rst_overflow", overflow, 0);

    // latency and order
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_z = 32'h3F800000; bus.in_status = 8'h00;
    chk("lat_empty_valid", bus.out_valid, 0);
    step();
    bus.in_z = 32'h40000000; bus.in_status = 8'h20;
    chk("lat_first_valid", bus.out_valid, 1);
    chk("lat_first_z", bus.out_z, 32'h3F800000);
    chk("lat_first_cnt", count, 1);
    step();
    bus.in_valid = 1'b0;
    chk("lat_second_z", bus.out_z, 32'h40000000);
    chk("lat_second_st", bus.out_status, 8'h20);
    chk("lat_second_cnt", count, 1);
    step();
    chk("lat_drain_cnt", count, 0);
    chk("lat_drain_z", bus.out_z, 0);
    chk("lat_drain_st", bus.out_status, 0);

    // full and drop
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1; bus.in_z = 32'h100 + 32'(i); bus.in_status = 8'h00;
      chk($sformatf("full_in_ready_%0d", i), bus.in_ready, (i < 8) ? 1 : 0);
      step();
    end
    bus.in_valid = 1'b0;
    chk("full_count", count, 8);
    chk("full_drop_count", drop_count, 1);
    chk("full_overflow", overflow, 1);
    chk("full_head", bus.out_z, 32'h100);

    // full with simultaneous pop: pushing still blocked this cycle
    bus.in_valid = 1'b1; bus.in_z = 32'hAAAA; bus.out_ready = 1'b1;
    chk("fullpop_in_ready", bus.in_ready, 0);
    step();
    bus.out_ready = 1'b0;
    chk("fullpop_count", count, 7);
    chk("fullpop_drop_count", drop_count, 2);
    chk("fullpop_in_ready_next", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("fullpop_refill_count", count, 8);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), bus.out_z, 32'h100 + 32'(i));
      step();
    end
    chk("drain_last", bus.out_z, 32'hAAAA);
    step();
    chk("drain_empty", count, 0);
    step();
    chk("empty_pop_no_underflow", count, 0);

    // pointer wrap with steady occupancy of 1
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_z = 32'h500;
    step();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      bus.in_z = 32'h500 + 32'(k);
      chk($sformatf("wrap_z_%0d", k), bus.out_z, 32'h500 + 32'(k - 1));
      chk($sformatf("wrap_cnt_%0d", k), count, 1);
      step();
    end
    bus.in_valid = 1'b0;
    chk("wrap_last", bus.out_z, 32'h514);
    step();
    chk("wrap_empty", count, 0);

    // sticky and exception counting
    chk("sticky_before_clr", sticky_status, 8'h20);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("clr_sticky", sticky_status, 0);
    chk("clr_drop", drop_count, 0);
    chk("clr_overflow", overflow, 0);
    bus.in_valid = 1'b1;
    bus.in_status = 8'h04; step();
    bus.in_status = 8'h02; step();
    bus.in_status = 8'h20; step();
    bus.in_valid = 1'b0;
    chk("sticky_or", sticky_status, 8'h26);
    chk("exc_count", exc_count, 2);
    bus.in_valid = 1'b1; bus.in_status = 8'h04; sticky_clr = 1'b1;
    step();
    bus.in_valid = 1'b0; sticky_clr = 1'b0;
    chk("clr_push_sticky", sticky_status, 8'h04);
    chk("clr_push_exc", exc_count, 1);
    step();

    // asynchronous reset mid-stream with three entries queued
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_status = 8'h10;
    step(); step(); step();
    bus.in_valid = 1'b0;
    chk("pre_rst_count", count, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_in_ready", bus.in_ready, 1);
    chk("async_rst_sticky", sticky_status, 0);
    chk("async_rst_exc", exc_count, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
